// File: rtl/risc_pkg.sv
// risc_pkg: constants and fetch entry type shared between the fetch and decode stages
package risc_pkg;
  localparam int XLEN = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous instruction/PC FIFO with flush; push and pop together are legal when full
module ifetch_fifo
  import risc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign count   = cnt_q;
  assign dout    = empty ? '0 : mem_q[rd_q];
  // pointers and occupancy; flush discards everything, including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage is unreset; the output mux shows zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner issuing in-order imem fetches, buffering words for decode, with redirect squash
module ifetch_unit
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d, squash_q, squash_d, count;
  logic [XLEN-1:0] tag_q [DEPTH];
  logic [AW-1:0]   tag_wr_q, tag_rd_q;
  logic            gnt, rv, fifo_full, fifo_empty;
  fetch_entry_t    wr_entry, head;
  assign imem_req   = rst_n & ~fifo_full & (({1'b0, count} + {1'b0, outst_q}) < (CW + 1)'(DEPTH));
  assign imem_addr  = pc_q;
  assign gnt        = imem_req & imem_gnt;
  assign rv         = imem_rvalid & (outst_q != '0);
  assign outst_d    = outst_q + CW'(gnt) - CW'(rv);
  assign wr_entry   = '{inst: imem_rdata, pc: tag_q[tag_rd_q]};
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_valid = ~fifo_empty;
  // next PC and squash budget; on redirect everything still in flight belongs to the old stream
  always_comb begin
    pc_d     = redirect ? (redirect_pc & ~32'd3) : gnt ? pc_q + PC_STEP : pc_q;
    squash_d = redirect ? outst_d : (rv && squash_q != '0) ? squash_q - CW'(1) : squash_q;
  end
  // PC, in-flight counters and tag queue pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      squash_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      squash_q <= squash_d;
      tag_wr_q <= tag_wr_q + AW'(gnt);
      tag_rd_q <= tag_rd_q + AW'(rv);
    end
  end
  // remember the PC of every granted request so its response can be tagged
  always_ff @(posedge clk) begin
    if (gnt) tag_q[tag_wr_q] <= pc_q;
  end
  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rv & ~redirect & (squash_q == '0)),
    .pop   (inst_ready),
    .flush (redirect),
    .din   (wr_entry),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed stimulus with an expected-PC scoreboard checked by an independent monitor
module tb_ifetch_unit;
  logic clk, rst_n, imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic rstn_v;
  int checks, errors, cyc, lat, grants;
  typedef struct { logic [31:0] a; int t; } mreq_t;
  mreq_t mq[$];
  logic [31:0] exp_q[$];

  ifetch_unit #(.RESET_PC(32'h100), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  // one clock cycle: drive inputs at negedge, then record the transfers the next posedge will take
  task automatic cycle(input logic g, input logic r, input logic rd = 1'b0, input logic [31:0] rpc = 32'h0);
    @(negedge clk);
    cyc++;
    rst_n = rstn_v;
    imem_gnt = g;
    inst_ready = r;
    redirect = rd;
    redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].t + lat <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = word(mq[0].a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = '0;
    end
    #1;
    if (imem_req && imem_gnt) begin
      mq.push_back('{imem_addr, cyc});
      grants++;
    end
    if (imem_rvalid) void'(mq.pop_front());
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_req"}, 32'(imem_req), 32'h0);
    chk({n, "_addr"}, imem_addr, 32'h100);
    chk({n, "_inst"}, inst, 32'h0);
    chk({n, "_inst_pc"}, inst_pc, 32'h0);
    chk({n, "_valid"}, 32'(inst_valid), 32'h0);
  endtask

  // monitor: every handshake to decode must match the next expected PC and its word
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra act_pc=%h exp=none", inst_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst, word(e));
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1; grants = 0;
    rst_n = 0; rstn_v = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; inst_ready = 0;
    repeat (3) cycle(0, 0);
    chk_reset("rst");
    // straight-line fetch from RESET_PC at one instruction per cycle
    rstn_v = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1);
      chk("t1_addr", imem_addr, 32'h100 + 32'(4 * i));
      chk("t1_req", 32'(imem_req), 32'h1);
      if (i == 1) chk("t1_valid_early", 32'(inst_valid), 32'h0);
      if (i == 2) chk("t1_valid_first", 32'(inst_valid), 32'h1);
    end
    repeat (6) cycle(0, 1);
    chk("t1_drained", 32'(exp_q.size()), 32'h0);
    // decoder stall: exactly DEPTH grants, then drain in order
    grants = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h120 + 32'(4 * i));
    repeat (10) cycle(1, 0);
    chk("t2_grants", 32'(grants), 32'h4);
    chk("t2_req_off", 32'(imem_req), 32'h0);
    chk("t2_valid", 32'(inst_valid), 32'h1);
    chk("t2_hold_pc", inst_pc, 32'h120);
    chk("t2_hold_inst", inst, word(32'h120));
    repeat (6) cycle(0, 1);
    chk("t2_drained", 32'(exp_q.size()), 32'h0);
    chk("t2_req_resume", 32'(imem_req), 32'h1);
    // redirect with three fetches outstanding at latency 3
    lat = 3;
    cycle(1, 1);
    cycle(1, 1);
    cycle(1, 1, 1'b1, 32'h2000);
    exp_q.push_back(32'h2000);
    cycle(1, 1);
    chk("t3_addr", imem_addr, 32'h2000);
    chk("t3_valid", 32'(inst_valid), 32'h0);
    repeat (8) cycle(0, 1);
    chk("t3_drained", 32'(exp_q.size()), 32'h0);
    // redirect together with a pop and an rvalid
    lat = 1;
    exp_q.push_back(32'h2004);
    exp_q.push_back(32'h3000);
    cycle(1, 1);
    cycle(1, 1);
    cycle(0, 1, 1'b1, 32'h3001);
    chk("t4_pop_pc", inst_pc, 32'h2004);
    cycle(1, 1);
    chk("t4_empty", 32'(inst_valid), 32'h0);
    chk("t4_addr", imem_addr, 32'h3000);
    repeat (4) cycle(0, 1);
    chk("t4_drained", 32'(exp_q.size()), 32'h0);
    // PC wraps modulo 2^32
    cycle(0, 1, 1'b1, 32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cycle(1, 1);
    chk("t5_addr0", imem_addr, 32'hFFFF_FFF8);
    cycle(1, 1);
    chk("t5_addr1", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 1);
    chk("t5_addr2", imem_addr, 32'h0);
    repeat (5) cycle(0, 1);
    chk("t5_drained", 32'(exp_q.size()), 32'h0);
    // asynchronous reset with two buffered entries
    cycle(1, 0);
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);
    chk("t6_valid_pre", 32'(inst_valid), 32'h1);
    chk("t6_pc_pre", inst_pc, 32'h4);
    #2;
    rst_n = 0;
    rstn_v = 0;
    #1;
    chk_reset("t6_async");
    mq.delete();
    cycle(0, 0);
    rstn_v = 1;
    exp_q.push_back(32'h100);
    cycle(1, 1);
    chk("t6_restart_addr", imem_addr, 32'h100);
    repeat (4) cycle(0, 1);
    chk("t6_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
